// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage data-memory sequencer. Watches the EX/MEM control/data fields,
// issues one request/response transaction per legal load or store, stalls the
// pipeline while it is outstanding and returns an aligned, extended load value.
//
// Parameters
//   TIMEOUT       1..255  cycles after REQ at which an unanswered access aborts
//
// Ports
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   memread_m/memwrite_m  load / store present in MEM (load wins if both set)
//   funct3_m              access size/sign (B, H, W, BU, HU)
//   alu_result_m          byte address
//   rs2_v_m               store data
//   dmem_req              one-cycle request pulse (registered)
//   dmem_we               1 = write (registered)
//   dmem_addr             word-aligned address (registered)
//   dmem_mask             byte enables (registered)
//   dmem_wdata            lane-shifted store data (registered)
//   dmem_resp/dmem_rdata  response strobe and raw read word
//   load_data_m           extended load result, held until the next load completes
//   stall_m               combinational freeze for all pipeline registers
//   misalign_err          one-cycle pulse, misaligned/undefined access dropped
//   timeout_err           one-cycle pulse, access aborted on timeout
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread_m,
   input  logic        memwrite_m,
   input  logic [2:0]  funct3_m,
   input  logic [31:0] alu_result_m,
   input  logic [31:0] rs2_v_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_mask,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_resp,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data_m,
   output logic        stall_m,
   output logic        misalign_err,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // The counter counts completed WAIT cycles. The abort is taken in the WAIT
   // cycle whose increment brings the counter to TIMEOUT-1, so the registered
   // error pulse (and DONE) land exactly TIMEOUT cycles after REQ. TIMEOUT=1
   // still grants one WAIT cycle.
   localparam logic [7:0] WAIT_LAST = (TIMEOUT > 1) ? 8'(TIMEOUT - 2) : 8'd0;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] load_q, load_d;
   logic        mis_q, mis_d;
   logic        to_q, to_d;

   // ---------------------------------------------------------------------------
   // Decode of the op currently presented by EX/MEM
   // ---------------------------------------------------------------------------
   logic        op;
   logic [1:0]  off;
   logic        f3_ok;
   logic        aligned;
   logic        legal;
   logic [3:0]  mask_calc;
   logic [31:0] wdata_calc;

   assign op  = memread_m | memwrite_m;
   assign off = alu_result_m[1:0];

   always_comb begin
      f3_ok     = 1'b0;
      aligned   = 1'b0;
      mask_calc = 4'b0000;
      case (funct3_m)
         3'b000, 3'b100: begin
            f3_ok     = 1'b1;
            aligned   = 1'b1;
            mask_calc = 4'b0001 << off;
         end
         3'b001, 3'b101: begin
            f3_ok     = 1'b1;
            aligned   = ~off[0];
            mask_calc = 4'b0011 << off;
         end
         3'b010: begin
            f3_ok     = 1'b1;
            aligned   = (off == 2'b00);
            mask_calc = 4'b1111;
         end
         default: begin
            f3_ok     = 1'b0;
            aligned   = 1'b0;
            mask_calc = 4'b0000;
         end
      endcase
   end

   assign legal      = op & f3_ok & aligned;
   assign wdata_calc = rs2_v_m << {off, 3'b000};

   // ---------------------------------------------------------------------------
   // Load extraction from the latched size/offset of the access in flight
   // ---------------------------------------------------------------------------
   logic [31:0] rd_shift;
   logic [31:0] load_ext;

   assign rd_shift = dmem_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = dmem_rdata;
      case (f3_q)
         3'b000:  load_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
         3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  load_ext = {24'd0, rd_shift[7:0]};
         3'b101:  load_ext = {16'd0, rd_shift[15:0]};
         default: load_ext = dmem_rdata;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      req_d   = 1'b0;
      we_d    = we_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      mis_d   = 1'b0;
      to_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (legal) begin
               f3_d    = funct3_m;
               off_d   = off;
               we_d    = ~memread_m;
               addr_d  = {alu_result_m[31:2], 2'b00};
               mask_d  = mask_calc;
               wdata_d = wdata_calc;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end else if (op) begin
               mis_d = 1'b1;
            end
         end
         ST_REQ: begin
            cnt_d   = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (dmem_resp) begin
               if (!we_q) begin
                  load_d = load_ext;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q >= WAIT_LAST) begin
                  to_d    = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         mask_q  <= 4'd0;
         wdata_q <= 32'd0;
         load_q  <= 32'd0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
      end
   end

   // Stall must rise in the same cycle the op appears, so it is decoded
   // combinationally; DONE is the single cycle that lets the instruction move.
   assign stall_m = ((state_q == ST_IDLE) && legal) ||
                    (state_q == ST_REQ) || (state_q == ST_WAIT);

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_mask    = mask_q;
   assign dmem_wdata   = wdata_q;
   assign load_data_m  = load_q;
   assign misalign_err = mis_q;
   assign timeout_err  = to_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Drives directed and random MEM-stage ops into mem_access_ctrl, plays the
// data memory with variable latency and stray responses, and checks every
// cycle against a transaction-level model of the expected outputs.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   localparam int TO   = 4;
   localparam int WMAX = (TO > 1) ? TO - 1 : 1;   // WAIT cycles before abort

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        memread, memwrite;
   logic [2:0]  funct3;
   logic [31:0] alu_result, rs2_v;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_mask;
   logic [31:0] load_data_m;
   logic        stall_m, misalign_err, timeout_err;

   mem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .memread_m    (memread),
      .memwrite_m   (memwrite),
      .funct3_m     (funct3),
      .alu_result_m (alu_result),
      .rs2_v_m      (rs2_v),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_mask    (dmem_mask),
      .dmem_wdata   (dmem_wdata),
      .dmem_resp    (dmem_resp),
      .dmem_rdata   (dmem_rdata),
      .load_data_m  (load_data_m),
      .stall_m      (stall_m),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_mis, exp_to, exp_bus, exp_we;
   logic [31:0] exp_addr, exp_wdata, exp_load;
   logic [3:0]  exp_mask;
   logic        pending_mis = 1'b0;
   logic        pending_to  = 1'b0;

   // Observations used by the literal checks
   int          stall_cnt = 0, req_cnt = 0, mis_cnt = 0, tcnt = 0, to_dist = -1;
   logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0;
   logic [3:0]  cap_mask = 4'd0;
   logic        cap_we   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: plain arithmetic on bytes
   // ---------------------------------------------------------------------------
   function automatic int m_size(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a);
      bit f3_ok;
      f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      return (rd || wr) && f3_ok && ((int'(a[1:0]) % m_size(f3)) == 0);
   endfunction

   function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] m;
      int off, n;
      off = int'(a[1:0]);
      n   = m_size(f3);
      for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
      return m;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [31:0] a);
      logic [31:0] r;
      int off;
      off = int'(a[1:0]);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = (i >= off) ? d[8*(i-off) +: 8] : 8'h00;
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
      int b[4];
      int off, v;
      off = int'(a[1:0]);
      for (int i = 0; i < 4; i++) b[i] = int'(w[8*i +: 8]);
      case (f3)
         3'd0: begin v = b[off]; if (v >= 128) v -= 256; return 32'(v); end
         3'd1: begin v = b[off] + 256*b[off+1]; if (v >= 32768) v -= 65536; return 32'(v); end
         3'd4: return 32'(b[off]);
         3'd5: return 32'(b[off] + 256*b[off+1]);
         default: return w;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Per-cycle compare
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall_m", 32'(stall_m), 32'(exp_stall));
         check("dmem_req", 32'(dmem_req), 32'(exp_req));
         check("misalign_err", 32'(misalign_err), 32'(exp_mis));
         check("timeout_err", 32'(timeout_err), 32'(exp_to));
         check("load_data_m", load_data_m, exp_load);
         if (exp_bus) begin
            check("dmem_we", 32'(dmem_we), 32'(exp_we));
            check("dmem_addr", dmem_addr, exp_addr);
            check("dmem_mask", 32'(dmem_mask), 32'(exp_mask));
            check("dmem_wdata", dmem_wdata, exp_wdata);
         end
         if (stall_m) stall_cnt++;
         if (misalign_err) mis_cnt++;
         if (dmem_req) begin
            req_cnt++;
            tcnt      = 0;
            cap_addr  = dmem_addr;
            cap_mask  = dmem_mask;
            cap_wdata = dmem_wdata;
            cap_we    = dmem_we;
         end else begin
            tcnt++;
         end
         if (timeout_err) to_dist = tcnt;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
      exp_mis     = pending_mis;
      exp_to      = pending_to;
      pending_mis = 1'b0;
      pending_to  = 1'b0;
      exp_stall   = 1'b0;
      exp_req     = 1'b0;
      exp_bus     = 1'b0;
      dmem_resp   = 1'b0;
   endtask

   task automatic nop_cycle();
      memread    = 1'b0;
      memwrite   = 1'b0;
      dmem_resp  = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      next_cycle();
   endtask

   // lat = WAIT cycle (1-based) carrying the response; lat > WMAX means none.
   task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int lat,
                        input logic [31:0] rdat);
      bit legal, got;
      memread    = rd;
      memwrite   = wr;
      funct3     = f3;
      alu_result = a;
      rs2_v      = d;
      legal      = m_legal(rd, wr, f3, a);
      $display("txn rd=%0b wr=%0b f3=%0d addr=%08h data=%08h lat=%0d legal=%0b rdata=%08h",
               rd, wr, f3, a, d, lat, legal, rdat);
      exp_stall  = legal;
      dmem_resp  = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      if (!legal) begin
         pending_mis = rd | wr;
         next_cycle();
         return;
      end
      next_cycle();                                    // REQ
      exp_stall  = 1'b1;
      exp_req    = 1'b1;
      exp_bus    = 1'b1;
      exp_we     = !rd;
      exp_addr   = {a[31:2], 2'b00};
      exp_mask   = m_mask(f3, a);
      exp_wdata  = m_wdata(d, a);
      dmem_resp  = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      got = 1'b0;
      for (int k = 1; k <= WMAX; k++) begin             // WAIT
         next_cycle();
         exp_stall = 1'b1;
         exp_bus   = 1'b1;
         if (k == lat) begin
            dmem_resp  = 1'b1;
            dmem_rdata = rdat;
            got        = 1'b1;
            break;
         end
      end
      if (!got) pending_to = 1'b1;
      next_cycle();                                    // DONE
      if (got && rd) exp_load = m_load(f3, a, rdat);
      dmem_resp  = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      next_cycle();
   endtask

   task automatic reset_in_wait();
      memread    = 1'b1;
      memwrite   = 1'b0;
      funct3     = 3'd2;
      alu_result = 32'h0000_5000;
      rs2_v      = 32'h1111_2222;
      $display("txn reset during WAIT of LW at %08h", alu_result);
      exp_stall  = 1'b1;
      next_cycle();
      exp_stall  = 1'b1;
      exp_req    = 1'b1;
      exp_bus    = 1'b1;
      exp_we     = 1'b0;
      exp_addr   = 32'h0000_5000;
      exp_mask   = m_mask(3'd2, 32'h0000_5000);
      exp_wdata  = m_wdata(rs2_v, 32'h0000_5000);
      next_cycle();
      exp_stall  = 1'b1;
      exp_bus    = 1'b1;
      #2;
      chk_en   = 1'b0;
      rst_n    = 1'b0;
      memread  = 1'b0;
      #1;
      check("rstw_req", 32'(dmem_req), 32'd0);
      check("rstw_we", 32'(dmem_we), 32'd0);
      check("rstw_addr", dmem_addr, 32'd0);
      check("rstw_mask", 32'(dmem_mask), 32'd0);
      check("rstw_wdata", dmem_wdata, 32'd0);
      check("rstw_load", load_data_m, 32'd0);
      check("rstw_stall", 32'(stall_m), 32'd0);
      check("rstw_mis", 32'(misalign_err), 32'd0);
      check("rstw_to", 32'(timeout_err), 32'd0);
      exp_load = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      chk_en     = 1'b1;
      dmem_resp  = 1'b1;                               // late response, must be dropped
      dmem_rdata = 32'h1234_5678;
      next_cycle();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h8765_4321;
      next_cycle();
      check("rstw_late_resp_load", load_data_m, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic        rd, wr;
      int          pick, lat;

      rst_n      = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      funct3     = 3'd0;
      alu_result = 32'd0;
      rs2_v      = 32'd0;
      dmem_resp  = 1'b0;
      dmem_rdata = 32'd0;
      exp_load   = 32'd0;
      exp_stall  = 1'b0;
      exp_req    = 1'b0;
      exp_mis    = 1'b0;
      exp_to     = 1'b0;
      exp_bus    = 1'b0;
      exp_we     = 1'b0;
      exp_addr   = 32'd0;
      exp_mask   = 4'd0;
      exp_wdata  = 32'd0;

      #12;
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_mask", 32'(dmem_mask), 32'd0);
      check("rst_load", load_data_m, 32'd0);
      check("rst_stall", 32'(stall_m), 32'd0);
      check("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
      memread    = 1'b1;
      funct3     = 3'd2;
      alu_result = 32'h0000_0100;
      #1;
      check("rst_stall_legal_op", 32'(stall_m), 32'd1);
      memread = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      chk_en = 1'b1;

      // LW 0x1000, response one cycle after REQ
      stall_cnt = 0;
      do_op(1'b1, 1'b0, 3'd2, 32'h0000_1000, 32'h0, 1, 32'hDEAD_BEEF);
      check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
      check("lw_addr", cap_addr, 32'h0000_1000);
      check("lw_mask", 32'(cap_mask), 32'hF);
      check("lw_we", 32'(cap_we), 32'd0);
      check("lw_data", load_data_m, 32'hDEAD_BEEF);

      // LB / LBU at 0x2003
      do_op(1'b1, 1'b0, 3'd0, 32'h0000_2003, 32'h0, 2, 32'h8011_2233);
      check("lb_mask", 32'(cap_mask), 32'h8);
      check("lb_data", load_data_m, 32'hFFFF_FF80);
      do_op(1'b1, 1'b0, 3'd4, 32'h0000_2003, 32'h0, 1, 32'h8011_2233);
      check("lbu_data", load_data_m, 32'h0000_0080);

      // SH at 0x3002
      do_op(1'b0, 1'b1, 3'd1, 32'h0000_3002, 32'h0000_ABCD, 1, 32'hFFFF_FFFF);
      check("sh_we", 32'(cap_we), 32'd1);
      check("sh_mask", 32'(cap_mask), 32'hC);
      check("sh_wdata", cap_wdata, 32'hABCD_0000);
      check("sh_addr", cap_addr, 32'h0000_3000);
      check("sh_load_kept", load_data_m, 32'h0000_0080);

      // Misaligned LW at 0x4001
      stall_cnt = 0;
      req_cnt   = 0;
      mis_cnt   = 0;
      do_op(1'b1, 1'b0, 3'd2, 32'h0000_4001, 32'h0, 1, 32'h0);
      nop_cycle();
      check("mis_stall_cycles", 32'(stall_cnt), 32'd0);
      check("mis_req_count", 32'(req_cnt), 32'd0);
      check("mis_pulses", 32'(mis_cnt), 32'd1);

      // Timeout with response held low, then a late response
      to_dist = -1;
      do_op(1'b1, 1'b0, 3'd2, 32'h0000_6000, 32'h0, WMAX + 1, 32'h0);
      memread    = 1'b0;
      memwrite   = 1'b0;
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      next_cycle();
      nop_cycle();
      check("to_distance", 32'(to_dist), 32'(TO));
      check("to_load_kept", load_data_m, 32'h0000_0080);

      reset_in_wait();

      // Random traffic
      for (int n = 0; n < 150; n++) begin
         pick = $urandom_range(0, 4);
         rd   = (pick == 1) || (pick == 2) || (pick == 4);
         wr   = (pick == 3) || (pick == 4);
         pick = $urandom_range(0, 9);
         case (pick)
            0, 1:    f3 = 3'd0;
            2, 3:    f3 = 3'd1;
            4, 5:    f3 = 3'd2;
            6:       f3 = 3'd4;
            7:       f3 = 3'd5;
            8:       f3 = 3'd3;
            default: f3 = 3'($urandom_range(6, 7));
         endcase
         a = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & ~32'(m_size(f3) - 1);
         lat = ($urandom_range(0, 7) == 0) ? WMAX + 1 : $urandom_range(1, WMAX);
         do_op(rd, wr, f3, a, $urandom, lat, $urandom);
      end
      nop_cycle();
      nop_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
